// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: a pixel-rate divider, horizontal and vertical
// position counters, registered sync/blanking decode and raster synchronisation strobes.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             hSync,
   output logic             vSync,
   output logic             bright,
   output logic [CNT_W-1:0] hCount,
   output logic [CNT_W-1:0] vCount,
   output logic             pixTick,
   output logic             lineStart,
   output logic             frameStart
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div;
   logic             advance;
   logic [CNT_W-1:0] h_next;
   logic [CNT_W-1:0] v_next;

   // Next raster position; only committed on an advancing edge.
   always_comb begin
      advance = enable && (div == DIV_W'(CLK_DIV - 1));
      h_next  = hCount + CNT_W'(1);
      v_next  = vCount;
      if (hCount == CNT_W'(H_TOTAL - 1)) begin
         h_next = '0;
         v_next = (vCount == CNT_W'(V_TOTAL - 1)) ? '0 : vCount + CNT_W'(1);
      end
   end

   // NOTE: non-blocking assignments keep every register updating from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         div        <= DIV_W'(CLK_DIV - 1);
         hCount     <= CNT_W'(H_TOTAL - 1);
         vCount     <= CNT_W'(V_TOTAL - 1);
         bright     <= 1'b0;
         hSync      <= ~HS_POL;
         vSync      <= ~VS_POL;
         pixTick    <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else begin
         pixTick    <= 1'b0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
         if (advance) begin
            div        <= '0;
            hCount     <= h_next;
            vCount     <= v_next;
            bright     <= (h_next < CNT_W'(H_ACTIVE)) && (v_next < CNT_W'(V_ACTIVE));
            hSync      <= (h_next >= CNT_W'(HS_START) && h_next <= CNT_W'(HS_END)) ? HS_POL : ~HS_POL;
            vSync      <= (v_next >= CNT_W'(VS_START) && v_next <= CNT_W'(VS_END)) ? VS_POL : ~VS_POL;
            pixTick    <= 1'b1;
            lineStart  <= (h_next == '0);
            frameStart <= (h_next == '0) && (v_next == '0);
         end else if (enable) begin
            div <= div + DIV_W'(1);
         end
      end
   end

endmodule
